// File: rtl/teclado_pkg.sv
// Shared key-code constants, controller state enum and key classification helper
// for the keypad entry controller.
package teclado_pkg;

  localparam logic [3:0] TECLA_APAGA   = 4'hA;
  localparam logic [3:0] TECLA_ENTER   = 4'hE;
  localparam logic [3:0] TECLA_LIMPA   = 4'hF;
  localparam logic [3:0] TECLA_NENHUMA = 4'hF;

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    ENTRADA      = 2'd1,
    ESPERA_SAIDA = 2'd2
  } estado_t;

  function automatic logic eh_digito(input logic [3:0] v);
    return (v <= 4'd9);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector on the decoder's tecla_valid: one-cycle event pulse plus
// the key code sampled in that same cycle (TECLA_NENHUMA when no event).
module detector_borda
  import teclado_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tecla_valid,
  input  logic [3:0] tecla_value,
  output logic       evento,
  output logic [3:0] valor
);

  logic valid_q;
  logic valid_d;

  always_comb begin
    valid_d = tecla_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // A held key stays high, so only the first cycle differs from the registered copy.
  assign evento = tecla_valid & ~valid_q;
  assign valor  = evento ? tecla_value : TECLA_NENHUMA;

endmodule

// File: rtl/controlador_entrada_teclado.sv
// Assembles keypad events into a multi-digit BCD code and hands it off over valid/ready.
// Build option: define CONTROLADOR_TIMEOUT_EN to discard an idle partial entry after TIMEOUT_CYC cycles.
module controlador_entrada_teclado
  import teclado_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    tecla_value,
  input  logic                          tecla_valid,
  output logic [4*N_DIGITS-1:0]         codigo,
  output logic [$clog2(N_DIGITS+1)-1:0] codigo_len,
  output logic                          codigo_valid,
  input  logic                          codigo_ready,
  output logic                          erro
);

  localparam int W     = 4 * N_DIGITS;
  localparam int LEN_W = $clog2(N_DIGITS + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N_DIGITS);

  logic            evento;
  logic [3:0]      valor;
  estado_t         estado_q, estado_d;
  logic [W-1:0]    codigo_q, codigo_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic            erro_q, erro_d;
  logic            tmo_expira;
  logic [W+3:0]    desloc;

  detector_borda u_detector_borda (
    .clk         (clk),
    .rst         (rst),
    .tecla_valid (tecla_valid),
    .tecla_value (tecla_value),
    .evento      (evento),
    .valor       (valor)
  );

`ifdef CONTROLADOR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances while a partial entry sits idle; any key event restarts it.
  always_comb begin
    cnt_d      = '0;
    tmo_expira = 1'b0;
    if (estado_q == ENTRADA && !evento) begin
      if (cnt_q == CNT_MAX) begin
        tmo_expira = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_expira = 1'b0;
`endif

  // Newest digit enters at the bottom; the oldest falls off the top when truncated.
  assign desloc = {codigo_q, valor};

  always_comb begin
    estado_d = estado_q;
    codigo_d = codigo_q;
    len_d    = len_q;
    erro_d   = 1'b0;
    case (estado_q)
      OCIOSO, ENTRADA: begin
        if (evento) begin
          if (eh_digito(valor)) begin
            if (len_q == LEN_MAX) begin
              erro_d = 1'b1;
            end else begin
              codigo_d = desloc[W-1:0];
              len_d    = len_q + 1'b1;
              estado_d = ENTRADA;
            end
          end else if (valor == TECLA_APAGA) begin
            if (len_q == '0) begin
              erro_d = 1'b1;
            end else begin
              codigo_d = codigo_q >> 4;
              len_d    = len_q - 1'b1;
              if (len_q == LEN_W'(1)) begin
                estado_d = OCIOSO;
              end
            end
          end else if (valor == TECLA_LIMPA) begin
            codigo_d = '0;
            len_d    = '0;
            estado_d = OCIOSO;
          end else if (valor == TECLA_ENTER) begin
            if (len_q != '0) begin
              estado_d = ESPERA_SAIDA;
            end
          end
        end else if (tmo_expira) begin
          codigo_d = '0;
          len_d    = '0;
          estado_d = OCIOSO;
          erro_d   = 1'b1;
        end
      end
      ESPERA_SAIDA: begin
        // Key events are ignored here, so an edge coinciding with the transfer is dropped.
        if (codigo_ready) begin
          codigo_d = '0;
          len_d    = '0;
          estado_d = OCIOSO;
        end
      end
      default: begin
        codigo_d = '0;
        len_d    = '0;
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= OCIOSO;
      codigo_q <= '0;
      len_q    <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      codigo_q <= codigo_d;
      len_q    <= len_d;
      erro_q   <= erro_d;
    end
  end

  assign codigo       = codigo_q;
  assign codigo_len   = len_q;
  assign codigo_valid = (estado_q == ESPERA_SAIDA);
  assign erro         = erro_q;

endmodule

// File: tb/tb_controlador_entrada_teclado.sv
// Scoreboard bench for controlador_entrada_teclado (N_DIGITS=4, TIMEOUT_CYC=100).
module tb_controlador_entrada_teclado;

  typedef struct {
    logic [15:0] c;
    logic [2:0]  l;
    int          vc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  tecla_value = 4'h0;
  logic        tecla_valid = 1'b0;
  logic [15:0] codigo;
  logic [2:0]  codigo_len;
  logic        codigo_valid;
  logic        codigo_ready = 1'b0;
  logic        erro;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int erro_hi = 0;
  int vtot = 0;
  int vcnt = 0;
  bit post = 0;

  controlador_entrada_teclado #(.N_DIGITS(4), .TIMEOUT_CYC(100)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .tecla_value  (tecla_value),
    .tecla_valid  (tecla_valid),
    .codigo       (codigo),
    .codigo_len   (codigo_len),
    .codigo_valid (codigo_valid),
    .codigo_ready (codigo_ready),
    .erro         (erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic push(input logic [15:0] c, input logic [2:0] l, input int vc);
    exp_t e;
    e.c = c; e.l = l; e.vc = vc;
    q.push_back(e);
  endtask

  task automatic press(input logic [3:0] v, input int hold);
    @(posedge clk); #2;
    tecla_value = v;
    tecla_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #2;
    tecla_valid = 1'b0;
    tecla_value = 4'h0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Monitor: compares every presented code against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vcnt = 0;
      post = 0;
    end else begin
      if (post) begin
        checks++;
        if (codigo !== 16'h0 || codigo_len !== 3'd0 || codigo_valid !== 1'b0) begin
          errors++;
          $display("FAIL post_transfer: got codigo=%h len=%0d valid=%b expected 0/0/0",
                   codigo, codigo_len, codigo_valid);
        end
        post = 0;
      end
      if (erro === 1'b1) erro_hi++;
      if (codigo_valid === 1'b1) begin
        vcnt++;
        vtot++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got codigo=%h len=%0d with no code expected", codigo, codigo_len);
        end else begin
          if (codigo !== q[0].c || codigo_len !== q[0].l) begin
            errors++;
            $display("FAIL code_held: got codigo=%h len=%0d expected codigo=%h len=%0d",
                     codigo, codigo_len, q[0].c, q[0].l);
          end
          if (codigo_ready === 1'b1) begin
            e = q.pop_front();
            if (e.vc >= 0) begin
              checks++;
              if (vcnt != e.vc) begin
                errors++;
                $display("FAIL valid_cycles: got %0d expected %0d", vcnt, e.vc);
              end
            end
            vcnt = 0;
            post = 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int v0;
    bit got;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("reset_codigo", 32'(codigo), 32'h0);
    chk("reset_len", 32'(codigo_len), 32'h0);
    chk("reset_valid", 32'(codigo_valid), 32'h0);
    chk("reset_erro", 32'(erro), 32'h0);
    rst_n = 1'b1;

    // T1: 1,2,3 then enter with ready already high
    codigo_ready = 1'b1;
    press(4'h1, 20);
    press(4'h2, 20);
    press(4'h3, 20);
    chk("t1_codigo", 32'(codigo), 32'h0123);
    chk("t1_len", 32'(codigo_len), 32'd3);
    push(16'h0123, 3'd3, 1);
    @(posedge clk); #2;
    tecla_value = 4'hE;
    tecla_valid = 1'b1;
    @(posedge clk); #2;
    chk("t1_latency", 32'(codigo_valid), 32'd1);
    repeat (19) @(posedge clk);
    #2;
    tecla_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t1_after_codigo", 32'(codigo), 32'h0);
    chk("t1_after_len", 32'(codigo_len), 32'd0);

    // T2: overflow on the 5th digit, then a stalled handshake
    codigo_ready = 1'b0;
    press(4'h1, 20);
    press(4'h2, 20);
    press(4'h3, 20);
    press(4'h4, 20);
    e0 = erro_hi;
    press(4'h5, 20);
    chk("t2_overflow_erro", 32'(erro_hi - e0), 32'd1);
    chk("t2_codigo", 32'(codigo), 32'h1234);
    chk("t2_len", 32'(codigo_len), 32'd4);
    push(16'h1234, 3'd4, 11);
    @(posedge clk); #2;
    tecla_value = 4'hE;
    tecla_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #2;
      if (codigo_valid === 1'b1) got = 1;
    end
    chk("t2_valid_seen", 32'(got), 32'd1);
    repeat (10) @(posedge clk);
    #2;
    codigo_ready = 1'b1;
    tecla_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t2_after_valid", 32'(codigo_valid), 32'd0);

    // T3: edit with backspace, then backspace on empty
    press(4'h7, 20);
    press(4'h8, 20);
    press(4'hA, 20);
    press(4'h9, 20);
    chk("t3_codigo", 32'(codigo), 32'h0079);
    chk("t3_len", 32'(codigo_len), 32'd2);
    push(16'h0079, 3'd2, 1);
    press(4'hE, 20);
    e0 = erro_hi;
    press(4'hA, 20);
    chk("t3_bksp_empty_erro", 32'(erro_hi - e0), 32'd1);
    chk("t3_bksp_empty_len", 32'(codigo_len), 32'd0);

    // T4: clear, empty enter, ignored key
    e0 = erro_hi;
    press(4'h4, 20);
    press(4'h5, 20);
    chk("t4_pre_clear", 32'(codigo), 32'h0045);
    press(4'hF, 20);
    chk("t4_clear_codigo", 32'(codigo), 32'h0);
    chk("t4_clear_len", 32'(codigo_len), 32'd0);
    v0 = vtot;
    press(4'hE, 20);
    press(4'hB, 20);
    chk("t4_empty_enter_valid", 32'(vtot - v0), 32'd0);
    chk("t4_no_erro", 32'(erro_hi - e0), 32'd0);
    chk("t4_ignored_len", 32'(codigo_len), 32'd0);

    // T5: long hold, keys during handoff, async reset mid-entry
    codigo_ready = 1'b0;
    press(4'h3, 200);
    chk("t5_hold_len", 32'(codigo_len), 32'd1);
    chk("t5_hold_codigo", 32'(codigo), 32'h0003);
    push(16'h0003, 3'd1, -1);
    press(4'hE, 5);
    press(4'h5, 5);
    press(4'hF, 5);
    chk("t5_waiting_codigo", 32'(codigo), 32'h0003);
    chk("t5_waiting_valid", 32'(codigo_valid), 32'd1);
    codigo_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    press(4'h6, 10);
    press(4'h2, 10);
    chk("t5_pre_reset", 32'(codigo), 32'h0062);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_codigo", 32'(codigo), 32'h0);
    chk("t5_async_len", 32'(codigo_len), 32'd0);
    chk("t5_async_valid", 32'(codigo_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // T6: idle partial entry
    press(4'h6, 20);
    e0 = erro_hi;
    repeat (1000) @(posedge clk);
    #2;
`ifdef CONTROLADOR_TIMEOUT_EN
    chk("t6_timeout_erro", 32'(erro_hi - e0), 32'd1);
    chk("t6_timeout_len", 32'(codigo_len), 32'd0);
`else
    chk("t6_no_timeout_erro", 32'(erro_hi - e0), 32'd0);
    chk("t6_no_timeout_len", 32'(codigo_len), 32'd1);
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
